rtc_bus_sequencer: RTL and testbench

- Sequences every access to the external RTC's multiplexed address/data bus, timing the ChipSelect, Read, Write and AoD strobes.
- Arbitrates the bus between two requesters: the write port (PicoBlaze/keyboard edits, time/chrono programming) and the read port (periodic refresh feeding the display registers).
- Sits between the requesters and the top-level tristate on DATA_ADDRESS; the top ties bus_o/bus_oe/bus_i to the inout pin.

---
 rtl/rtc_bus_sequencer.sv | 160 ++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// Six-phase sequencer for the RTC multiplexed address/data bus, arbitrating a write port and a read port.
// Define RTC_SEQ_FIXED_PRI_EN for fixed write-over-read priority; otherwise round-robin.
module rtc_bus_sequencer #(
  parameter int PHASE_CYC = 10,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] wr_data,
  output logic          wr_done,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [AW-1:0] rd_data,
  output logic          rd_done,
  output logic          busy,
  output logic [AW-1:0] bus_o,
  output logic          bus_oe,
  input  logic [AW-1:0] bus_i,
  output logic          ChipSelect,
  output logic          Read,
  output logic          Write,
  output logic          AoD
);
  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_rd_q, op_rd_d;
  logic [AW-1:0] addr_q, addr_d, data_q, data_d;
  logic          rr_last_rd_q, rr_last_rd_d;
  logic          cs_q, cs_d, rdn_q, rdn_d, wrn_q, wrn_d, aod_q, aod_d, oe_q, oe_d;
  logic [AW-1:0] bo_q, bo_d, rdat_q, rdat_d;
  logic          wdone_q, wdone_d, rdone_q, rdone_d;
  logic          phase_end, grant_rd;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    op_rd_d      = op_rd_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rr_last_rd_d = rr_last_rd_q;
    rdat_d       = rdat_q;
    wdone_d      = 1'b0;
    rdone_d      = 1'b0;
    phase_end    = (cnt_q == CW'(PHASE_CYC - 1));
`ifdef RTC_SEQ_FIXED_PRI_EN
    grant_rd     = !wr_req;
`else
    // On a tie, serve whichever side was not served last.
    grant_rd     = rd_req && (!wr_req || !rr_last_rd_q);
`endif

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (wr_req || rd_req) begin
        op_rd_d      = grant_rd;
        addr_d       = grant_rd ? rd_addr : wr_addr;
        data_d       = wr_data;
        rr_last_rd_d = grant_rd;
        state_d      = A_SET;
      end
    end else if (phase_end) begin
      cnt_d = '0;
      if (state_q == D_STB && op_rd_q) rdat_d = bus_i;
      if (state_q == D_HLD) begin
        state_d = IDLE;
        wdone_d = !op_rd_q;
        rdone_d = op_rd_q;
      end else begin
        state_d = state_e'(state_q + 3'd1);
      end
    end

    // Bus/strobe values are decoded from the next state so they leave a flop cleanly.
    cs_d  = 1'b1;
    rdn_d = 1'b1;
    wrn_d = 1'b1;
    aod_d = 1'b1;
    oe_d  = 1'b0;
    bo_d  = '0;
    case (state_d)
      A_SET, A_HLD: begin
        aod_d = 1'b0;
        oe_d  = 1'b1;
        bo_d  = addr_d;
      end
      A_STB: begin
        aod_d = 1'b0;
        oe_d  = 1'b1;
        bo_d  = addr_d;
        cs_d  = 1'b0;
        wrn_d = 1'b0;
      end
      D_SET, D_HLD: begin
        oe_d = !op_rd_d;
        bo_d = op_rd_d ? '0 : data_d;
      end
      D_STB: begin
        oe_d  = !op_rd_d;
        bo_d  = op_rd_d ? '0 : data_d;
        cs_d  = 1'b0;
        rdn_d = !op_rd_d;
        wrn_d = op_rd_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_rd_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      rr_last_rd_q <= 1'b1;
      cs_q         <= 1'b1;
      rdn_q        <= 1'b1;
      wrn_q        <= 1'b1;
      aod_q        <= 1'b1;
      oe_q         <= 1'b0;
      bo_q         <= '0;
      rdat_q       <= '0;
      wdone_q      <= 1'b0;
      rdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_rd_q      <= op_rd_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rr_last_rd_q <= rr_last_rd_d;
      cs_q         <= cs_d;
      rdn_q        <= rdn_d;
      wrn_q        <= wrn_d;
      aod_q        <= aod_d;
      oe_q         <= oe_d;
      bo_q         <= bo_d;
      rdat_q       <= rdat_d;
      wdone_q      <= wdone_d;
      rdone_q      <= rdone_d;
    end
  end

  assign ChipSelect = cs_q;
  assign Read       = rdn_q;
  assign Write      = wrn_q;
  assign AoD        = aod_q;
  assign bus_oe     = oe_q;
  assign bus_o      = bo_q;
  assign rd_data    = rdat_q;
  assign wr_done    = wdone_q;
  assign rd_done    = rdone_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: directed stimulus pushes expected transactions, a monitor checks bus and done pulses.
module tb_rtc_bus_sequencer;
  localparam int PC = 2;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       wr_req = 1'b0, rd_req = 1'b0;
  logic [7:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic [7:0] rd_data, bus_o, bus_i, rd_model = 8'h00;
  logic       wr_done, rd_done, busy, bus_oe, ChipSelect, Read, Write, AoD;

  rtc_bus_sequencer #(.PHASE_CYC(PC), .AW(8)) dut (
    .clk(clk), .Reset(Reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .busy(busy), .bus_o(bus_o), .bus_oe(bus_oe), .bus_i(bus_i),
    .ChipSelect(ChipSelect), .Read(Read), .Write(Write), .AoD(AoD)
  );

  always #5 clk = ~clk;

  // RTC model: drives its register value only while Read is low.
  assign bus_i = (!Read) ? rd_model : 8'h00;

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, start_cyc = 0;
  logic prev_busy = 1'b0, prev_aod = 1'b1, prev_cs = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit rd, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.rd = rd; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: protocol invariants, bus contents against scoreboard head, done pulses.
  always @(negedge clk) begin
    cyc++;
    if (!Reset) begin
      chk("read_write_exclusive", {31'd0, !Read && !Write}, 32'd0);
      if (AoD !== prev_aod) chk("cs_high_on_aod_edge", {30'd0, prev_cs, ChipSelect}, 32'd3);
      if (busy && !prev_busy) start_cyc = cyc;
      if (busy) begin
        if (exp_q.size() == 0) chk("unexpected_grant", 32'd1, 32'd0);
        else if (!AoD) begin
          chk("addr_phase_oe", {31'd0, bus_oe}, 32'd1);
          chk("addr_phase_bus", {24'd0, bus_o}, {24'd0, exp_q[0].addr});
        end else if (exp_q[0].rd) begin
          chk("read_data_phase_oe", {31'd0, bus_oe}, 32'd0);
        end else begin
          chk("write_data_phase_oe", {31'd0, bus_oe}, 32'd1);
          chk("write_data_phase_bus", {24'd0, bus_o}, {24'd0, exp_q[0].data});
        end
      end
      if (wr_done || rd_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_kind", {30'd0, rd_done, wr_done}, e.rd ? 32'd2 : 32'd1);
          chk("done_latency", cyc - start_cyc, 6 * PC);
          if (e.rd) chk("rd_data", {24'd0, rd_data}, {24'd0, e.data});
        end
      end
    end
    prev_busy = busy;
    prev_aod  = AoD;
    prev_cs   = ChipSelect;
  end

  task automatic wait_done(input bit rd);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rd ? rd_done : wr_done) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    if (rd) rd_req = 1'b0; else wr_req = 1'b0;
  endtask

  initial begin
    int n_done;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {26'd0, ChipSelect, Read, Write, AoD, bus_oe, busy}, 32'b111100);
    chk("rst_bus_o", {24'd0, bus_o}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_done", {30'd0, wr_done, rd_done}, 32'd0);
    Reset = 1'b0;
    @(negedge clk);

    // Single write with cycle-exact strobe timing (grant cycle = 0).
    wr_addr = 8'h21; wr_data = 8'h45; wr_req = 1'b1;
    push(0, 8'h21, 8'h45);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk("wr_cs", {31'd0, ChipSelect}, (k == 3 || k == 4 || k == 9 || k == 10) ? 32'd0 : 32'd1);
      chk("wr_write", {31'd0, Write}, (k == 3 || k == 4 || k == 9 || k == 10) ? 32'd0 : 32'd1);
      chk("wr_aod", {31'd0, AoD}, (k >= 1 && k <= 6) ? 32'd0 : 32'd1);
      chk("wr_read_high", {31'd0, Read}, 32'd1);
      chk("wr_done_pulse", {31'd0, wr_done}, (k == 13) ? 32'd1 : 32'd0);
      if (k == 13) wr_req = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Single read; RTC returns 8'h37.
    rd_model = 8'h37; rd_addr = 8'h22; rd_req = 1'b1;
    push(1, 8'h22, 8'h37);
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("rd_data_hold", {24'd0, rd_data}, 32'h37);

    // Both requesters held for four transactions.
    rd_model = 8'h5A; rd_addr = 8'h32; wr_addr = 8'h31; wr_data = 8'hA5;
`ifdef RTC_SEQ_FIXED_PRI_EN
    for (int i = 0; i < 4; i++) push(0, 8'h31, 8'hA5);
`else
    for (int i = 0; i < 4; i++) push(i % 2 == 1, (i % 2 == 1) ? 8'h32 : 8'h31, (i % 2 == 1) ? 8'h5A : 8'hA5);
`endif
    wr_req = 1'b1; rd_req = 1'b1;
    n_done = 0;
    for (int i = 0; i < 400 && n_done < 4; i++) begin
      @(negedge clk);
      if (wr_done || rd_done) n_done++;
    end
    chk("alt_done_count", n_done, 32'd4);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);

    // Inputs change and request drops one cycle after grant.
    wr_addr = 8'h40; wr_data = 8'h66; wr_req = 1'b1;
    push(0, 8'h40, 8'h66);
    @(negedge clk);
    @(negedge clk);
    wr_addr = 8'hFF; wr_data = 8'h00; wr_req = 1'b0;
    wait_done(0);
    repeat (2) @(negedge clk);

    // Reset during D_STB of a write aborts it without a done.
    wr_addr = 8'h50; wr_data = 8'h77; wr_req = 1'b1;
    push(0, 8'h50, 8'h77);
    begin
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (!ChipSelect && AoD) hit = 1;
      end
      chk("reach_d_stb", {31'd0, hit}, 32'd1);
    end
    Reset = 1'b1; wr_req = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    chk("abort_outputs", {28'd0, ChipSelect, Write, bus_oe, busy}, 32'b1100);
    chk("abort_no_done", {30'd0, wr_done, rd_done}, 32'd0);
    Reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_rd_data", {24'd0, rd_data}, 32'd0);

    wr_addr = 8'h51; wr_data = 8'h78; wr_req = 1'b1;
    push(0, 8'h51, 8'h78);
    wait_done(0);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
